stream_downsize: RTL and testbench

STREAM_DOWNSIZE -- requirements
Module: stream_downsize

---
 rtl/stream_pkg.sv | 15 +
 rtl/stream_downsize_lowest_set_enc.sv | 28 ++
 rtl/stream_downsize.sv | 104 ++++++++++
 tb/tb_stream_downsize.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converters: FSM state encoding
// and the lane-index width helper.
package stream_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  // At least one bit so a single-lane index is still a legal vector.
  function automatic int lane_idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_downsize_lowest_set_enc.sv
// Lowest-set-bit encoder: reports the index and one-hot of the lowest set bit
// of a mask, and whether that bit is the only one left.
module lowest_set_enc
  import stream_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = lane_idx_width(N)
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] index,
  output logic [N-1:0]  onehot,
  output logic          single
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IW'(i);
      end
    end
  end

  assign onehot = mask & (~mask + N'(1));
  assign single = (mask != '0) && ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: splits each accepted wide beat into its
// kept lanes, lowest index first, with a one-beat holding register.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int IW = lane_idx_width(T_DATA_RATIO);

  state_t                  state_q, state_d;
  logic [T_DATA_RATIO-1:0] keep_q, keep_d;
  logic                    last_q, last_d;
  logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];

  logic [IW-1:0]           lane_idx;
  logic [T_DATA_RATIO-1:0] lane_onehot;
  logic                    lane_single;
  logic                    pop;
  logic                    load;

  lowest_set_enc #(
    .N  (T_DATA_RATIO),
    .IW (IW)
  ) u_enc (
    .mask   (keep_q),
    .index  (lane_idx),
    .onehot (lane_onehot),
    .single (lane_single)
  );

  assign m_valid_o = (state_q == ST_BUSY);
  assign pop       = m_valid_o && m_ready_i;
  // Ready again on the cycle the final lane leaves, so wide beats chain without a bubble.
  assign s_ready_o = (state_q == ST_EMPTY) || (pop && lane_single);
  assign load      = s_valid_i && s_ready_o;

  // Data is gated while idle because the lane registers are never reset.
  assign m_data_o  = m_valid_o ? data_q[lane_idx] : '0;
  assign m_last_o  = m_valid_o && last_q && lane_single;

  always_comb begin
    state_d = state_q;
    keep_d  = keep_q;
    last_d  = last_q;

    if (load) begin
      keep_d = s_keep_i;
      last_d = s_last_i && (|s_keep_i);
    end else if (pop) begin
      keep_d = keep_q & ~lane_onehot;
    end

    case (state_q)
      ST_EMPTY: begin
        if (load && (|s_keep_i)) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (keep_d == '0) begin
          state_d = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load) begin
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        data_q[i] <= s_data_i[i];
      end
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed and randomized checks of stream_downsize on a 2-lane and a 4-lane
// instance, with a scoreboard for the randomized traffic.
module tb_stream_downsize;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [3:0] s2_data [2];
  logic [1:0] s2_keep;
  logic       s2_last, s2_valid, s2_ready;
  logic [3:0] m2_data;
  logic       m2_last, m2_valid, m2_ready;

  logic [3:0] s4_data [4];
  logic [3:0] s4_keep;
  logic       s4_last, s4_valid, s4_ready;
  logic [3:0] m4_data;
  logic       m4_last, m4_valid, m4_ready;

  int total = 0;
  int bad   = 0;

  stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .s_data_i(s2_data), .s_keep_i(s2_keep), .s_last_i(s2_last),
    .s_valid_i(s2_valid), .s_ready_o(s2_ready),
    .m_data_o(m2_data), .m_last_o(m2_last), .m_valid_o(m2_valid),
    .m_ready_i(m2_ready)
  );

  stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .s_data_i(s4_data), .s_keep_i(s4_keep), .s_last_i(s4_last),
    .s_valid_i(s4_valid), .s_ready_o(s4_ready),
    .m_data_o(m4_data), .m_last_o(m4_last), .m_valid_o(m4_valid),
    .m_ready_i(m4_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3,
                               input logic [3:0] keep, input logic last, input logic mr);
    s4_valid   = v;
    s4_data[0] = d0;
    s4_data[1] = d1;
    s4_data[2] = d2;
    s4_data[3] = d3;
    s4_keep    = keep;
    s4_last    = last;
    m4_ready   = mr;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [3:0] ed,
                             input logic el, input logic er);
    chk({tag, ".m_valid"}, 32'(m4_valid), 32'(ev));
    chk({tag, ".s_ready"}, 32'(s4_ready), 32'(er));
    if (ev) begin
      chk({tag, ".m_data"}, 32'(m4_data), 32'(ed));
      chk({tag, ".m_last"}, 32'(m4_last), 32'(el));
    end
  endtask

  // Scoreboard for the randomized phase on the 4-lane instance.
  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  logic mon_en   = 1'b0;
  int   in_last  = 0;
  int   out_last = 0;
  int   out_n    = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m4_valid && m4_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_lane", 32'(m4_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("rand_data%0d", out_n), 32'(m4_data), 32'(e.data));
          chk($sformatf("rand_last%0d", out_n), 32'(m4_last), 32'(e.last));
        end
        if (m4_last) out_last++;
        out_n++;
      end
      if (s4_valid && s4_ready) begin
        int hi;
        hi = -1;
        for (int i = 0; i < 4; i++) if (s4_keep[i]) hi = i;
        for (int i = 0; i < 4; i++) begin
          if (s4_keep[i]) exp_q.push_back('{data: s4_data[i], last: s4_last && (i == hi)});
        end
        if (s4_last && (s4_keep != 4'b0000)) in_last++;
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    logic acc;

    rst        = 1'b1;
    s2_data[0] = 4'h0;
    s2_data[1] = 4'h0;
    s2_keep    = 2'b00;
    s2_last    = 1'b0;
    s2_valid   = 1'b0;
    m2_ready   = 1'b0;
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    repeat (2) nextCycle();
    settle();
    chk("reset2.m_valid", 32'(m2_valid), 32'd0);
    chk("reset2.m_last",  32'(m2_last),  32'd0);
    chk("reset2.m_data",  32'(m2_data),  32'd0);
    chk("reset2.s_ready", 32'(s2_ready), 32'd1);
    chk("reset4.m_last",  32'(m4_last),  32'd0);
    chk("reset4.m_data",  32'(m4_data),  32'd0);
    checkOutput("reset4", 1'b0, 4'h0, 1'b0, 1'b1);

    // Two-lane beat {B,A}, last set, sink always ready.
    nextCycle();
    rst        = 1'b0;
    s2_data[0] = 4'hA;
    s2_data[1] = 4'hB;
    s2_keep    = 2'b11;
    s2_last    = 1'b1;
    s2_valid   = 1'b1;
    m2_ready   = 1'b1;
    settle();
    chk("r2_accept.s_ready", 32'(s2_ready), 32'd1);
    chk("r2_accept.m_valid", 32'(m2_valid), 32'd0);
    nextCycle();
    s2_valid = 1'b0;
    settle();
    chk("r2_lane0.m_valid", 32'(m2_valid), 32'd1);
    chk("r2_lane0.m_data",  32'(m2_data),  32'hA);
    chk("r2_lane0.m_last",  32'(m2_last),  32'd0);
    chk("r2_lane0.s_ready", 32'(s2_ready), 32'd0);
    nextCycle();
    settle();
    chk("r2_lane1.m_valid", 32'(m2_valid), 32'd1);
    chk("r2_lane1.m_data",  32'(m2_data),  32'hB);
    chk("r2_lane1.m_last",  32'(m2_last),  32'd1);
    chk("r2_lane1.s_ready", 32'(s2_ready), 32'd1);
    nextCycle();
    settle();
    chk("r2_idle.m_valid", 32'(m2_valid), 32'd0);
    chk("r2_idle.s_ready", 32'(s2_ready), 32'd1);

    // Sparse keep 1010: only lanes 1 and 3 come out.
    nextCycle();
    applyStimulus(1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 4'b1010, 1'b1, 1'b1);
    settle();
    checkOutput("k1010_accept", 1'b0, 4'h0, 1'b0, 1'b1);
    nextCycle();
    s4_valid = 1'b0;
    settle();
    checkOutput("k1010_lane1", 1'b1, 4'h2, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("k1010_lane3", 1'b1, 4'h4, 1'b1, 1'b1);
    nextCycle();
    settle();
    checkOutput("k1010_idle", 1'b0, 4'h0, 1'b0, 1'b1);

    // Full beat, all-dropped beat, full beat.
    nextCycle();
    applyStimulus(1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 4'b1111, 1'b0, 1'b1);
    settle();
    checkOutput("zk_x_accept", 1'b0, 4'h0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 4'h9, 4'h9, 4'h9, 4'h9, 4'b0000, 1'b1, 1'b1);
    settle();
    checkOutput("zk_x0", 1'b1, 4'h1, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("zk_x1", 1'b1, 4'h2, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("zk_x2", 1'b1, 4'h3, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("zk_x3", 1'b1, 4'h4, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 4'h5, 4'h6, 4'h7, 4'h8, 4'b1111, 1'b1, 1'b1);
    settle();
    checkOutput("zk_drop", 1'b0, 4'h0, 1'b0, 1'b1);
    nextCycle();
    s4_valid = 1'b0;
    settle();
    checkOutput("zk_y0", 1'b1, 4'h5, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("zk_y1", 1'b1, 4'h6, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("zk_y2", 1'b1, 4'h7, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("zk_y3", 1'b1, 4'h8, 1'b1, 1'b1);
    nextCycle();
    settle();
    checkOutput("zk_idle", 1'b0, 4'h0, 1'b0, 1'b1);

    // Sink stalls for three cycles on lane 0; idle input bus carries junk.
    nextCycle();
    applyStimulus(1'b1, 4'hA, 4'hB, 4'hC, 4'hD, 4'b1111, 1'b1, 1'b0);
    settle();
    checkOutput("stall_accept", 1'b0, 4'h0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("stall%0d", i), 1'b1, 4'hA, 1'b0, 1'b0);
      nextCycle();
    end
    m4_ready = 1'b1;
    settle();
    checkOutput("stall_rel_a", 1'b1, 4'hA, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("stall_rel_b", 1'b1, 4'hB, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("stall_rel_c", 1'b1, 4'hC, 1'b0, 1'b0);
    nextCycle();
    settle();
    checkOutput("stall_rel_d", 1'b1, 4'hD, 1'b1, 1'b1);
    nextCycle();
    settle();
    checkOutput("stall_idle", 1'b0, 4'h0, 1'b0, 1'b1);

    // Reset lands mid-beat after lane 0 has gone out.
    nextCycle();
    applyStimulus(1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 4'b1111, 1'b1, 1'b1);
    settle();
    checkOutput("rst_accept", 1'b0, 4'h0, 1'b0, 1'b1);
    nextCycle();
    s4_valid = 1'b0;
    settle();
    checkOutput("rst_lane0", 1'b1, 4'h1, 1'b0, 1'b0);
    nextCycle();
    rst = 1'b1;
    settle();
    checkOutput("rst_busy", 1'b1, 4'h2, 1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;
    settle();
    checkOutput("rst_after", 1'b0, 4'h0, 1'b0, 1'b1);
    chk("rst_after.m_data", 32'(m4_data), 32'd0);
    chk("rst_after.m_last", 32'(m4_last), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      settle();
      checkOutput($sformatf("rst_quiet%0d", i), 1'b0, 4'h0, 1'b0, 1'b1);
    end

    // Randomized traffic against the scoreboard.
    nextCycle();
    mon_en = 1'b1;
    sent   = 0;
    cyc    = 0;
    applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    while (sent < 1000 && cyc < 30000) begin
      settle();
      acc = s4_valid && s4_ready;
      nextCycle();
      cyc++;
      if (acc) begin
        sent++;
        for (int i = 0; i < 4; i++) s4_data[i] = 4'($urandom_range(0, 15));
        s4_keep = 4'($urandom_range(0, 15));
        s4_last = 1'($urandom_range(0, 1));
      end
      s4_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      m4_ready = 1'($urandom_range(0, 1));
    end
    s4_valid = 1'b0;
    m4_ready = 1'b1;
    repeat (8) nextCycle();
    settle();
    mon_en = 1'b0;
    chk("rand_beats_sent", 32'(sent), 32'd1000);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_last_count", 32'(out_last), 32'(in_last));
    chk("rand_drained", 32'(m4_valid), 32'd0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
